front_redirect_sched: RTL
=========================

// Module: front_redirect_sched
// PURPOSE
//  Front-end scheduler between PC, IF/ID and ID/EX. Chooses next PC from the ID redirect, IF direct jump or sequential/predicted path.
//  Sequences stalls for load-use (1-cycle bubble) and multi-cycle mult/div (whole front frozen).
//  Holds an ID redirect that arrives during a freeze and applies it on resume; counts flushes.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC value driven on npc while in reset
//  MD_CYCLES   32             front-freeze length for mult/div, in cycles; legal range 1..255
//  CNT_W       16             width of saturating flush counter
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous, active-low reset
//  load_use      in   1      ID instruction needs EX load result
//  md_start      in   1      ID issues mult/div this cycle
//  id_redirect   in   1      ID resolved mispredict or jr/jalr; redirect required
//  id_target     in   32     target for id_redirect
//  if_jump       in   1      IF holds j/jal
//  if_target     in   32     {PC[31:28],idx,2'b00} from IF
//  seq_npc       in   32     predictor's normal next PC (PC+4 or predicted branch target)
//  npc           out  32     next PC value
//  pc_we         out  1      PC register load enable
//  ifid_we       out  1      IF/ID load enable
//  ifid_clr      out  1      IF/ID clear; takes priority over ifid_we
//  idex_we       out  1      ID/EX load enable
//  idex_clr      out  1      ID/EX bubble insert
//  busy          out  1      1 while in MD_WAIT
//  flush_cnt     out  CNT_W  number of ifid_clr pulses since reset; saturates at all-ones
// BEHAVIOUR
//  Reset (rst=0, async): state=RUN, md_cnt=0, pend_v=0, flush_cnt=0.
//   Outputs held at npc=RESET_PC, pc_we=0, ifid_we=0, idex_we=0, ifid_clr=1, idex_clr=1, busy=0.
//  States: RUN, MD_WAIT, RESUME. Outputs are combinational from state+inputs; no added latency.
//  RUN, priority high->low:
//   1 load_use: pc_we=0, ifid_we=0, idex_clr=1. id_redirect and md_start are ignored, not latched. Stay RUN.
//   2 md_start: pc_we=ifid_we=idex_we=0. md_cnt<=MD_CYCLES-1.
//     Next state MD_WAIT if MD_CYCLES>1, else RESUME. If id_redirect is also set: pend_v<=1, pend_t<=id_target.
//   3 id_redirect: npc=id_target, pc_we=1, ifid_we=1, ifid_clr=1, idex_we=1.
//   4 if_jump: npc=if_target, all we=1.
//   5 else: npc=seq_npc, all we=1, no clears.
//  MD_WAIT: pc_we=ifid_we=idex_we=0, busy=1. md_cnt decrements each cycle. md_start and load_use are ignored.
//   First id_redirect seen with pend_v=0 latches pend_t/pend_v; later id_redirect values do not overwrite it.
//   When md_cnt==1 -> RESUME.
//   Total freeze = MD_CYCLES cycles, counting the md_start cycle.
//  RESUME (exactly one cycle):
//   If pend_v: npc=pend_t, pc_we=1, ifid_we=1, ifid_clr=1, idex_we=1; id_redirect/if_jump inputs ignored; pend_v<=0.
//   Else: same as RUN with the load_use and md_start rows disabled.
//   Always -> RUN.
//  idex_clr in RUN is driven only by load_use; the ID/EX bubble is separate from ifid_clr.
//  flush_cnt increments on every cycle with ifid_clr=1 while rst=1; holds at 2^CNT_W-1.
//  Reset mid-freeze: freeze and pending redirect are abandoned; state returns to RUN.
//  npc is fully width-preserving; no arithmetic on targets.
// TESTING
//  T1 seq_npc=0x40, no requests -> npc=0x40, pc_we=ifid_we=idex_we=1, clears 0.
//  T2 id_redirect=1, id_target=0x100, if_jump=1, if_target=0x200 in RUN
//     -> npc=0x100, ifid_clr=1, flush_cnt 0->1.
//  T3 load_use=1, id_redirect=1 -> pc_we=ifid_we=0, idex_clr=1;
//     next cycle id_redirect=1 alone -> redirect taken.
//  T4 MD_CYCLES=4, md_start at cycle 0 -> pc_we=0 in cycles 0..3, busy=1 in 1..3, pc_we=1 at cycle 4.
//     With id_target=0x300 in cycle 2 -> npc=0x300, ifid_clr=1 at cycle 4.
//  T5 drop rst to 0 asynchronously mid-MD_WAIT -> npc=RESET_PC and clears=1 immediately;
//     after release, state=RUN, busy=0, and no pending redirect is applied.
//  T6 CNT_W=2, 5 redirects -> flush_cnt=3 (saturated).

Source files
------------

// File: rtl/front_redirect_sched.sv
// -----------------------------------------------------------------------------
// front_redirect_sched
//
// Front-end scheduler sitting between the PC register, IF/ID and ID/EX.
// Picks the next PC from (high to low) an ID-stage redirect, an IF-stage
// direct jump, or the predictor's sequential/predicted path. It also
// sequences the two kinds of front-end stall:
//   - load-use: a one-cycle bubble into ID/EX while PC and IF/ID hold.
//   - mult/div: the whole front end freezes for MD_CYCLES cycles.
// An ID redirect that shows up while the front end is frozen is parked and
// replayed in the single RESUME cycle. Every IF/ID clear is counted in a
// saturating flush counter.
//
// Handshake/enable semantics: each *_we is a load enable for the register it
// names, sampled on the rising clk edge. A *_clr forces that register to a
// bubble and wins over the matching *_we. All outputs are combinational
// from the current state and inputs, so the decision applies in the same
// cycle the request is presented.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      asynchronous, active-low reset
//   load_use     in   1      ID instruction needs EX load result
//   md_start     in   1      ID issues mult/div this cycle
//   id_redirect  in   1      ID resolved mispredict or jr/jalr
//   id_target    in   32     target for id_redirect
//   if_jump      in   1      IF holds j/jal
//   if_target    in   32     jump target computed in IF
//   seq_npc      in   32     predictor's normal next PC
//   npc          out  32     next PC value
//   pc_we        out  1      PC register load enable
//   ifid_we      out  1      IF/ID load enable
//   ifid_clr     out  1      IF/ID clear (priority over ifid_we)
//   idex_we      out  1      ID/EX load enable
//   idex_clr     out  1      ID/EX bubble insert
//   busy         out  1      high while waiting on mult/div
//   flush_cnt    out  CNT_W  IF/ID clear pulses since reset, saturating
//   dbg_state    out  2      current FSM state (0=RUN, 1=MD_WAIT, 2=RESUME)
// -----------------------------------------------------------------------------
module front_redirect_sched #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MD_CYCLES = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             md_start,
  input  logic             id_redirect,
  input  logic [31:0]      id_target,
  input  logic             if_jump,
  input  logic [31:0]      if_target,
  input  logic [31:0]      seq_npc,
  output logic [31:0]      npc,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_clr,
  output logic             idex_we,
  output logic             idex_clr,
  output logic             busy,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MD_WAIT = 2'd1,
    ST_RESUME  = 2'd2
  } state_t;

  // Counter preload: the md_start cycle itself is the first frozen cycle.
  localparam logic [7:0] MD_LOAD  = 8'(MD_CYCLES - 1);
  localparam logic       MD_MULTI = (MD_CYCLES > 1);

  state_t           r_state;
  logic [7:0]       r_md_cnt;
  logic             r_pend_v;
  logic [31:0]      r_pend_t;
  logic [CNT_W-1:0] r_flush_cnt;

  state_t           w_state_n;
  logic [7:0]       w_md_cnt_n;
  logic             w_pend_v_n;
  logic [31:0]      w_pend_t_n;
  logic [31:0]      w_npc;
  logic             w_pc_we;
  logic             w_ifid_we;
  logic             w_ifid_clr;
  logic             w_idex_we;
  logic             w_idex_clr;
  logic             w_busy;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_md_cnt    <= 8'd0;
      r_pend_v    <= 1'b0;
      r_pend_t    <= 32'd0;
      r_flush_cnt <= '0;
    end else begin
      r_state  <= w_state_n;
      r_md_cnt <= w_md_cnt_n;
      r_pend_v <= w_pend_v_n;
      r_pend_t <= w_pend_t_n;
      if (w_ifid_clr && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_n  = r_state;
    w_md_cnt_n = r_md_cnt;
    w_pend_v_n = r_pend_v;
    w_pend_t_n = r_pend_t;
    w_npc      = seq_npc;
    w_pc_we    = 1'b0;
    w_ifid_we  = 1'b0;
    w_ifid_clr = 1'b0;
    w_idex_we  = 1'b0;
    w_idex_clr = 1'b0;
    w_busy     = 1'b0;

    unique case (r_state)
      ST_RUN: begin
        if (load_use) begin
          // Hold PC and IF/ID; ID/EX takes a bubble. Redirect and mult/div
          // are dropped here and will be re-presented by ID next cycle.
          w_idex_we  = 1'b1;
          w_idex_clr = 1'b1;
        end else if (md_start) begin
          w_md_cnt_n = MD_LOAD;
          w_state_n  = MD_MULTI ? ST_MD_WAIT : ST_RESUME;
          if (id_redirect) begin
            w_pend_v_n = 1'b1;
            w_pend_t_n = id_target;
          end
        end else if (id_redirect) begin
          w_npc      = id_target;
          w_pc_we    = 1'b1;
          w_ifid_we  = 1'b1;
          w_ifid_clr = 1'b1;
          w_idex_we  = 1'b1;
        end else if (if_jump) begin
          w_npc     = if_target;
          w_pc_we   = 1'b1;
          w_ifid_we = 1'b1;
          w_idex_we = 1'b1;
        end else begin
          w_pc_we   = 1'b1;
          w_ifid_we = 1'b1;
          w_idex_we = 1'b1;
        end
      end

      ST_MD_WAIT: begin
        w_busy     = 1'b1;
        w_md_cnt_n = r_md_cnt - 8'd1;
        // Only the first redirect during a freeze is kept.
        if (id_redirect && !r_pend_v) begin
          w_pend_v_n = 1'b1;
          w_pend_t_n = id_target;
        end
        if (r_md_cnt == 8'd1) begin
          w_state_n = ST_RESUME;
        end
      end

      ST_RESUME: begin
        w_state_n = ST_RUN;
        w_pc_we   = 1'b1;
        w_ifid_we = 1'b1;
        w_idex_we = 1'b1;
        if (r_pend_v) begin
          w_npc      = r_pend_t;
          w_ifid_clr = 1'b1;
          w_pend_v_n = 1'b0;
        end else if (id_redirect) begin
          w_npc      = id_target;
          w_ifid_clr = 1'b1;
        end else if (if_jump) begin
          w_npc = if_target;
        end
      end

      default: begin
        w_state_n = ST_RUN;
      end
    endcase
  end

  // While reset is asserted the outputs are forced directly, so the front end
  // sees the reset vector and clears without waiting for a clock edge.
  assign npc       = rst ? w_npc      : RESET_PC;
  assign pc_we     = rst ? w_pc_we    : 1'b0;
  assign ifid_we   = rst ? w_ifid_we  : 1'b0;
  assign ifid_clr  = rst ? w_ifid_clr : 1'b1;
  assign idex_we   = rst ? w_idex_we  : 1'b0;
  assign idex_clr  = rst ? w_idex_clr : 1'b1;
  assign busy      = rst ? w_busy     : 1'b0;
  assign flush_cnt = r_flush_cnt;
  assign dbg_state = r_state;

endmodule
